// File: rtl/kfpga_io_cfg_pkg.sv
// Shared types and sizing helpers for the IO tile config loader.
// Latency/backpressure: none (types and constants only).
package kfpga_io_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      COMMIT = 3'd2,
      DONE   = 3'd3,
      ERROR  = 3'd4
   } state_t;

   localparam int DEFAULT_NB_TILES     = 4;
   localparam int DEFAULT_CONFIG_WIDTH = 24;
   localparam int DEFAULT_DATA_WIDTH   = 8;

   function automatic int total_words(input int nb_tiles, input int config_width,
                                      input int data_width);
      return (nb_tiles * config_width) / data_width;
   endfunction

endpackage

// File: rtl/io_config_shift_reg.sv
// Shadow register: words shift in from the MSB end so the first word ends up in the LSBs.
// Latency: 1 cycle per shift; no backpressure, the caller gates shift_en.
module io_config_shift_reg
   import kfpga_io_cfg_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_NB_TILES * DEFAULT_CONFIG_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  clear,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [WIDTH-1:0]      shadow
);

   always_ff @(posedge clock) begin
      if (!nreset) begin
         shadow <= '0;
      end else if (clear) begin
         shadow <= '0;
      end else if (shift_en) begin
         shadow <= {data_in, shadow[WIDTH-1:DATA_WIDTH]};
      end
   end

endmodule

// File: rtl/io_tile_config_loader.sv
// Streams config words into a shadow register, then commits every IO tile's slice in one cycle.
// Latency: config_out and done update 1 cycle after the last word; data_ready only in LOAD. Optional parity: IO_CONFIG_PARITY_EN.
module io_tile_config_loader
   import kfpga_io_cfg_pkg::*;
#(
   parameter int NB_TILES     = DEFAULT_NB_TILES,
   parameter int CONFIG_WIDTH = DEFAULT_CONFIG_WIDTH,
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
   input  logic                             clock,
   input  logic                             nreset,
   input  logic                             start,
   input  logic                             abort,
   input  logic [DATA_WIDTH-1:0]            data_in,
   input  logic                             data_parity,
   input  logic                             data_valid,
   output logic                             data_ready,
   output logic [NB_TILES*CONFIG_WIDTH-1:0] config_out,
   output logic                             busy,
   output logic                             done,
   output logic                             error
);

   localparam int CFG_W       = NB_TILES * CONFIG_WIDTH;
   localparam int TOTAL_WORDS = total_words(NB_TILES, CONFIG_WIDTH, DATA_WIDTH);
   localparam int CNT_W       = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(TOTAL_WORDS - 1);

   generate
      if (CONFIG_WIDTH % DATA_WIDTH != 0) begin : g_bad_width
         $error("CONFIG_WIDTH must be a multiple of DATA_WIDTH");
      end
   endgenerate

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] word_cnt;
   logic [CFG_W-1:0] shadow;
   logic             accept;
   logic             parity_ok;
   logic             last_word;
   logic             load_start;
   logic             shift_en;

   assign accept     = data_valid & data_ready;
   assign last_word  = (word_cnt == LAST_WORD);
   assign load_start = start & (state_q inside {IDLE, DONE, ERROR});
   // abort beats both the shift and the parity check
   assign shift_en   = accept & ~abort & parity_ok;

`ifdef IO_CONFIG_PARITY_EN
   assign parity_ok = ~(^{data_in, data_parity});
`else
   logic unused_parity;
   assign unused_parity = data_parity;
   assign parity_ok     = 1'b1;
`endif

   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) state_d = LOAD;
         end
         LOAD: begin
            if (abort) begin
               state_d = IDLE;
            end else if (accept) begin
               if (!parity_ok)     state_d = ERROR;
               else if (last_word) state_d = COMMIT;
            end
         end
         COMMIT:  state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      data_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      case (state_q)
         LOAD: begin
            data_ready = 1'b1;
            busy       = 1'b1;
         end
         COMMIT: busy = 1'b1;
         DONE:   done = 1'b1;
         ERROR: begin
`ifdef IO_CONFIG_PARITY_EN
            error = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         word_cnt   <= '0;
         config_out <= '0;
      end else begin
         if (load_start)    word_cnt <= '0;
         else if (shift_en) word_cnt <= word_cnt + CNT_W'(1);
         if (state_q == COMMIT) config_out <= shadow;
      end
   end

   io_config_shift_reg #(
      .WIDTH      (CFG_W),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_shadow (
      .clock    (clock),
      .nreset   (nreset),
      .clear    (load_start),
      .shift_en (shift_en),
      .data_in  (data_in),
      .shadow   (shadow)
   );

endmodule

// File: tb/tb_io_tile_config_loader.sv
// Directed bench for io_tile_config_loader at default parameters.
module tb_io_tile_config_loader;

   logic        clock = 1'b0;
   logic        nreset;
   logic        start;
   logic        abort;
   logic [7:0]  data_in;
   logic        data_parity;
   logic        data_valid;
   logic        data_ready;
   logic [95:0] config_out;
   logic        busy;
   logic        done;
   logic        error;

   int total = 0;
   int bad   = 0;

   localparam logic [95:0] EXP_SEQ  = 96'h0C0B0A_090807_060504_030201;
   localparam logic [95:0] EXP_A0   = 96'hABAAA9_A8A7A6_A5A4A3_A2A1A0;
   localparam logic [95:0] EXP_ONES = {96{1'b1}};

   io_tile_config_loader dut (
      .clock       (clock),
      .nreset      (nreset),
      .start       (start),
      .abort       (abort),
      .data_in     (data_in),
      .data_parity (data_parity),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .config_out  (config_out),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [7:0] word_of(input int mode, input int idx);
      case (mode)
         0:       return 8'(idx + 1);
         1:       return 8'hFF;
         default: return 8'(8'hA0 + idx);
      endcase
   endfunction

   // Starts a load from IDLE/DONE/ERROR and streams 12 words until done is seen.
   task automatic run_load(input int mode, input bit toggle, input bit hold_start,
                           output int rdy_cnt, output int busy_cnt,
                           output bit held, output bit ok);
      logic [95:0] prev;
      int idx;
      bit acc;
      prev = config_out;
      idx = 0; rdy_cnt = 0; busy_cnt = 0; held = 1'b1; ok = 1'b0;
      start = 1'b1;
      tick();
      if (!hold_start) start = 1'b0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (data_ready) rdy_cnt++;
         if (busy) busy_cnt++;
         if (config_out !== prev) held = 1'b0;
         data_valid  = (idx < 12) && (!toggle || (cyc % 2 == 1));
         data_in     = word_of(mode, idx);
         data_parity = ^data_in;
         acc = data_valid && data_ready;
         tick();
         if (acc) idx++;
      end
      data_valid = 1'b0;
      start      = 1'b0;
   endtask

   task automatic test_reset();
      nreset = 1'b0; start = 1'b0; abort = 1'b0;
      data_in = 8'h00; data_parity = 1'b0; data_valid = 1'b0;
      tick(); tick();
      total++; if (config_out !== 96'h0) begin bad++; $display("FAIL reset_config got=%h exp=0", config_out); end
      total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", data_ready); end
      total++; if ({busy, done, error} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, error}); end
      nreset = 1'b1;
      tick();
      total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b exp=0", data_ready); end
   endtask

   task automatic test_back_to_back();
      int r, b; bit h, ok;
      run_load(0, 1'b0, 1'b0, r, b, h, ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=no_done exp=done"); end
      total++; if (r !== 12) begin bad++; $display("FAIL b2b_ready_cycles got=%0d exp=12", r); end
      total++; if (b !== 13) begin bad++; $display("FAIL b2b_busy_cycles got=%0d exp=13", b); end
      total++; if (config_out[23:0] !== 24'h030201) begin bad++; $display("FAIL b2b_tile0 got=%h exp=030201", config_out[23:0]); end
      total++; if (config_out[95:72] !== 24'h0C0B0A) begin bad++; $display("FAIL b2b_tile3 got=%h exp=0c0b0a", config_out[95:72]); end
      total++; if (config_out !== EXP_SEQ) begin bad++; $display("FAIL b2b_config got=%h exp=%h", config_out, EXP_SEQ); end
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done_level got=%b exp=1", done); end
   endtask

   task automatic test_toggle_valid();
      int r, b; bit h, ok;
      run_load(2, 1'b0, 1'b0, r, b, h, ok);
      total++; if (config_out !== EXP_A0) begin bad++; $display("FAIL pre_toggle_config got=%h exp=%h", config_out, EXP_A0); end
      run_load(0, 1'b1, 1'b0, r, b, h, ok);
      total++; if (!ok) begin bad++; $display("FAIL toggle_timeout got=no_done exp=done"); end
      total++; if (b !== 25) begin bad++; $display("FAIL toggle_busy_cycles got=%0d exp=25", b); end
      total++; if (r !== 24) begin bad++; $display("FAIL toggle_ready_cycles got=%0d exp=24", r); end
      total++; if (h !== 1'b1) begin bad++; $display("FAIL toggle_hold_before_commit got=%b exp=1", h); end
      total++; if (config_out !== EXP_SEQ) begin bad++; $display("FAIL toggle_config got=%h exp=%h", config_out, EXP_SEQ); end
   endtask

   task automatic test_abort();
      int r, b; bit h, ok;
      run_load(1, 1'b0, 1'b0, r, b, h, ok);
      total++; if (config_out !== EXP_ONES) begin bad++; $display("FAIL abort_ones_load got=%h exp=%h", config_out, EXP_ONES); end
      start = 1'b1; tick(); start = 1'b0;
      data_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data_in = 8'h11; data_parity = ^data_in;
         tick();
      end
      abort = 1'b1; data_in = 8'h22; data_parity = ^data_in;
      tick();
      abort = 1'b0; data_valid = 1'b0;
      total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", data_ready); end
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL abort_idle_flags got=%b exp=00", {busy, done}); end
      total++; if (config_out !== EXP_ONES) begin bad++; $display("FAIL abort_config_kept got=%h exp=%h", config_out, EXP_ONES); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_stays_idle got=%b exp=0", busy); end
      run_load(0, 1'b0, 1'b0, r, b, h, ok);
      total++; if (config_out !== EXP_SEQ) begin bad++; $display("FAIL after_abort_config got=%h exp=%h", config_out, EXP_SEQ); end
   endtask

   task automatic test_reset_mid_load();
      int r, b; bit h, ok;
      start = 1'b1; tick(); start = 1'b0;
      data_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         data_in = 8'h55; data_parity = ^data_in;
         tick();
      end
      data_valid = 1'b0;
      nreset = 1'b0;
      tick();
      total++; if (config_out !== 96'h0) begin bad++; $display("FAIL midreset_config got=%h exp=0", config_out); end
      total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL midreset_ready got=%b exp=0", data_ready); end
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midreset_flags got=%b exp=00", {busy, done}); end
      nreset = 1'b1;
      tick();
      run_load(2, 1'b0, 1'b0, r, b, h, ok);
      total++; if (!ok) begin bad++; $display("FAIL midreset_reload_timeout got=no_done exp=done"); end
      total++; if (config_out !== EXP_A0) begin bad++; $display("FAIL midreset_reload got=%h exp=%h", config_out, EXP_A0); end
   endtask

   task automatic test_hold_start();
      int r, b; bit h, ok;
      run_load(0, 1'b0, 1'b1, r, b, h, ok);
      total++; if (!ok) begin bad++; $display("FAIL hold_start_timeout got=no_done exp=done"); end
      total++; if (r !== 12) begin bad++; $display("FAIL hold_start_ready_cycles got=%0d exp=12", r); end
      total++; if (config_out !== EXP_SEQ) begin bad++; $display("FAIL hold_start_config got=%h exp=%h", config_out, EXP_SEQ); end
   endtask

   task automatic test_restart_in_done();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_pre_done got=%b exp=1", done); end
      start = 1'b1; tick(); start = 1'b0;
      total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL restart_flags got=%b exp=10", {busy, done}); end
      total++; if (dut.word_cnt !== 4'd0) begin bad++; $display("FAIL restart_counter got=%0d exp=0", dut.word_cnt); end
      data_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         data_in = (i == 0) ? 8'h5A : 8'h00;
         data_parity = ^data_in;
         tick();
      end
      data_valid = 1'b0;
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_done got=%b exp=1", done); end
      total++; if (config_out !== 96'h5A) begin bad++; $display("FAIL restart_tile0_first got=%h exp=5a", config_out); end
   endtask

   task automatic test_parity();
      logic [95:0] prev;
      int r, b; bit h, ok;
      prev = config_out;
      start = 1'b1; tick(); start = 1'b0;
      data_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         data_in = 8'(i + 1);
         data_parity = (i == 3) ? ~(^data_in) : ^data_in;
         tick();
`ifdef IO_CONFIG_PARITY_EN
         if (i == 3) break;
`endif
      end
      data_valid = 1'b0;
`ifdef IO_CONFIG_PARITY_EN
      total++; if (error !== 1'b1) begin bad++; $display("FAIL parity_error got=%b exp=1", error); end
      total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL parity_ready got=%b exp=0", data_ready); end
      total++; if (config_out !== prev) begin bad++; $display("FAIL parity_config_kept got=%h exp=%h", config_out, prev); end
      run_load(0, 1'b0, 1'b0, r, b, h, ok);
      total++; if (error !== 1'b0) begin bad++; $display("FAIL parity_error_cleared got=%b exp=0", error); end
      total++; if (config_out !== EXP_SEQ) begin bad++; $display("FAIL parity_reload got=%h exp=%h", config_out, EXP_SEQ); end
`else
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL noparity_done got=%b exp=1", done); end
      total++; if (error !== 1'b0) begin bad++; $display("FAIL noparity_error got=%b exp=0", error); end
      total++; if (config_out !== EXP_SEQ) begin bad++; $display("FAIL noparity_config got=%h exp=%h (prev %h)", config_out, EXP_SEQ, prev); end
      run_load(2, 1'b0, 1'b0, r, b, h, ok);
      total++; if (config_out !== EXP_A0) begin bad++; $display("FAIL noparity_reload got=%h exp=%h", config_out, EXP_A0); end
`endif
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_toggle_valid();
      test_abort();
      test_reset_mid_load();
      test_hold_start();
      test_restart_in_done();
      test_parity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
